// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and constants for the register file slice
package regfile_pkg;
   localparam int REG_W = 6;
   localparam int XLEN = 32;
   localparam int NREG = 64;
   localparam logic [REG_W-1:0] ZERO_IDX = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy vector, hazard stall and issue handshake
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             regwrite,
   input  logic [REG_W-1:0] rd,
   input  logic             issue_valid,
   input  logic             issue_regwrite,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_use_rs1,
   input  logic             issue_use_rs2,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic             stall,
   output logic             issued
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] busy_eff;

   always_comb begin
      busy_eff = busy_q;
      if (regwrite) busy_eff[rd] = 1'b0;
      stall = issue_valid & ((issue_use_rs1 & busy_eff[rs1]) |
                             (issue_use_rs2 & busy_eff[rs2]) |
                             (issue_regwrite & busy_eff[issue_rd]));
      issued = issue_valid & ~stall;

      // Set is applied after clear so a new producer wins over the retiring one.
      busy_d = busy_q;
      if (regwrite) busy_d[rd] = 1'b0;
      if (issued && issue_regwrite && issue_rd != ZERO_IDX) busy_d[issue_rd] = 1'b1;
      busy_d[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy_q <= '0;
      else       busy_q <= busy_d;
   end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 64x32 int/float register file with write bypass and issue scoreboard
module regfile
   import regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             regwrite,
   input  logic [REG_W-1:0] rd,
   input  logic [XLEN-1:0]  regwdata,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   input  logic             issue_valid,
   input  logic             issue_regwrite,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_use_rs1,
   input  logic             issue_use_rs2,
   output logic             stall,
   output logic             issued
);

   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];

   always_comb begin
      mem_d = mem_q;
      if (regwrite && rd != ZERO_IDX) mem_d[rd] = regwdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Bypass lets decode see a value in the same cycle it is written back.
   always_comb begin
      rs1_data = mem_q[rs1];
      if (regwrite && rd == rs1) rs1_data = regwdata;
      if (rs1 == ZERO_IDX)       rs1_data = '0;
      rs2_data = mem_q[rs2];
      if (regwrite && rd == rs2) rs2_data = regwdata;
      if (rs2 == ZERO_IDX)       rs2_data = '0;
   end

   regfile_scoreboard u_scoreboard (
      .clk            (clk),
      .rstn           (rstn),
      .regwrite       (regwrite),
      .rd             (rd),
      .issue_valid    (issue_valid),
      .issue_regwrite (issue_regwrite),
      .issue_rd       (issue_rd),
      .issue_use_rs1  (issue_use_rs1),
      .issue_use_rs2  (issue_use_rs2),
      .rs1            (rs1),
      .rs2            (rs2),
      .stall          (stall),
      .issued         (issued)
   );

endmodule
